// File: rtl/btn_debounce_multi.sv
// N-channel counter-based button debouncer: input synchroniser, stability filter,
// registered level plus one-cycle rise, fall and long-press pulses per channel.
module btn_debounce_multi #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 20,
  parameter int STABLE_CNT  = 50000,
  parameter int LONG_CNT    = 500000,
  parameter int SYNC_STAGES = 2,
  parameter int RST_VAL     = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_db,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] long_pulse
);

  localparam logic             RST_BIT   = (RST_VAL != 0);
  localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_M1   = CNT_W'(LONG_CNT - 1);

  logic [N_CH-1:0]  r_sync [SYNC_STAGES];
  logic [CNT_W-1:0] r_cnt  [N_CH];
  logic [CNT_W-1:0] r_hcnt [N_CH];
  logic [N_CH-1:0]  r_db;
  logic [N_CH-1:0]  r_rise;
  logic [N_CH-1:0]  r_fall;
  logic [N_CH-1:0]  r_long;

  logic [N_CH-1:0]  w_s;
  logic [N_CH-1:0]  w_db_next;
  logic [N_CH-1:0]  w_long_next;
  logic [CNT_W-1:0] w_cnt_next  [N_CH];
  logic [CNT_W-1:0] w_hcnt_next [N_CH];

  assign w_s = r_sync[SYNC_STAGES-1];

  // The hold counter parks at LONG_CNT-1; the pulse fires only on the cycle it arrives there.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_db_next[i]   = r_db[i];
      w_cnt_next[i]  = '0;
      w_hcnt_next[i] = '0;
      if (w_s[i] != r_db[i]) begin
        if (r_cnt[i] == STABLE_M1) w_db_next[i]  = w_s[i];
        else                       w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
      end
      if (r_db[i]) begin
        if (r_hcnt[i] < LONG_M1) w_hcnt_next[i] = r_hcnt[i] + CNT_W'(1);
        else                     w_hcnt_next[i] = r_hcnt[i];
      end
      w_long_next[i] = w_db_next[i] && (w_hcnt_next[i] == LONG_M1) &&
                       !(r_db[i] && (r_hcnt[i] == LONG_M1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= {N_CH{RST_BIT}};
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i]  <= '0;
        r_hcnt[i] <= '0;
      end
      r_db   <= {N_CH{RST_BIT}};
      r_rise <= '0;
      r_fall <= '0;
      r_long <= '0;
    end else begin
      r_sync[0] <= btn_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i]  <= w_cnt_next[i];
        r_hcnt[i] <= w_hcnt_next[i];
      end
      r_db   <= w_db_next;
      r_rise <= ~r_db & w_db_next;
      r_fall <= r_db & ~w_db_next;
      r_long <= w_long_next;
    end
  end

  assign btn_db     = r_db;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign long_pulse = r_long;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi: per-cycle vector table for reset, step and
// bounce, then hand-written sequences for long press, all-channel and mid-count reset.
module tb_btn_debounce_multi;

  logic       clk;
  logic       reset;
  logic [3:0] btn_in;
  logic [3:0] btn_db;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic [3:0] long_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic [3:0] db;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] lng;
  } vec_t;

  vec_t vecs[$];

  btn_debounce_multi #(
    .N_CH(4), .CNT_W(8), .STABLE_CNT(4), .LONG_CNT(10), .SYNC_STAGES(2), .RST_VAL(0)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_db(btn_db),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .long_pulse(long_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input logic rst, input logic [3:0] btn, input logic [3:0] db,
                         input logic [3:0] rise, input logic [3:0] fall, input logic [3:0] lng);
    vec_t v;
    v.rst = rst; v.btn = btn; v.db = db; v.rise = rise; v.fall = fall; v.lng = lng;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] db, input logic [3:0] rise,
                         input logic [3:0] fall, input logic [3:0] lng);
    chk({name, ".db"},   btn_db,     db);
    chk({name, ".rise"}, rise_pulse, rise);
    chk({name, ".fall"}, fall_pulse, fall);
    chk({name, ".long"}, long_pulse, lng);
  endtask

  // Drive inputs at the falling edge, let one rising edge sample them, check at the next fall.
  task automatic step(input logic rst, input logic [3:0] btn);
    reset  = rst;
    btn_in = btn;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset  = 1'b1;
    btn_in = 4'b0000;
    @(negedge clk);

    // Reset and idle
    for (int i = 0; i < 3; i++) add_vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_vec(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Clean step on ch0: level follows on the 6th sampling edge, then release
    for (int i = 0; i < 5; i++) add_vec(1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_vec(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    add_vec(1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) add_vec(1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add_vec(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add_vec(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Bounce on ch1: three high samples never reach terminal count
    for (int i = 0; i < 3; i++) add_vec(1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 6; i++) add_vec(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].btn);
      chk_all($sformatf("vec%0d", i), vecs[i].db, vecs[i].rise, vecs[i].fall, vecs[i].lng);
    end

    // Long press on ch2: rise on edge 6, single long pulse 9 clocks later
    for (int n = 1; n <= 20; n++) begin
      step(1'b0, 4'b0100);
      chk_all($sformatf("long.hold%0d", n), (n >= 6) ? 4'b0100 : 4'b0000,
              (n == 6) ? 4'b0100 : 4'b0000, 4'b0000, (n == 15) ? 4'b0100 : 4'b0000);
    end
    for (int n = 1; n <= 8; n++) begin
      step(1'b0, 4'b0000);
      chk_all($sformatf("long.rel%0d", n), (n < 6) ? 4'b0100 : 4'b0000, 4'b0000,
              (n == 6) ? 4'b0100 : 4'b0000, 4'b0000);
    end

    // All channels together
    for (int n = 1; n <= 8; n++) begin
      step(1'b0, 4'b1111);
      chk_all($sformatf("all.hold%0d", n), (n >= 6) ? 4'b1111 : 4'b0000,
              (n == 6) ? 4'b1111 : 4'b0000, 4'b0000, 4'b0000);
    end
    for (int n = 1; n <= 7; n++) begin
      step(1'b0, 4'b0000);
      chk_all($sformatf("all.rel%0d", n), (n < 6) ? 4'b1111 : 4'b0000, 4'b0000,
              (n == 6) ? 4'b1111 : 4'b0000, 4'b0000);
    end

    // Reset in the middle of a count on ch3 discards it
    for (int n = 1; n <= 4; n++) begin
      step(1'b0, 4'b1000);
      chk_all($sformatf("mid.pre%0d", n), 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    step(1'b1, 4'b1000);
    chk_all("mid.rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int n = 1; n <= 7; n++) begin
      step(1'b0, 4'b1000);
      chk_all($sformatf("mid.post%0d", n), (n >= 6) ? 4'b1000 : 4'b0000,
              (n == 6) ? 4'b1000 : 4'b0000, 4'b0000, 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
